// File: rtl/ctrl_pkg.sv
// Shared opcodes, control encodings and pipeline control bundles for ctrl_pipe.
// The bundles narrow stage by stage so each register holds only what later stages use.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ASEL_RS1  = 2'd0,
        ASEL_PC   = 2'd1,
        ASEL_ZERO = 2'd2
    } asel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        asel_e   a_sel;
        logic    branch;
        logic    jump;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        wb_sel_e mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        wb_sel_e mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic    reg_write;
        wb_sel_e mem_to_reg;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_ZERO     = '0;
    localparam mem_ctrl_t MEM_CTRL_ZERO = '0;
    localparam wb_ctrl_t  WB_CTRL_ZERO  = '0;

    function automatic mem_ctrl_t to_mem_ctrl(input ctrl_t c);
        mem_ctrl_t m;
        m.mem_read   = c.mem_read;
        m.mem_write  = c.mem_write;
        m.reg_write  = c.reg_write;
        m.mem_to_reg = c.mem_to_reg;
        return m;
    endfunction

    function automatic wb_ctrl_t to_wb_ctrl(input mem_ctrl_t c);
        wb_ctrl_t w;
        w.reg_write  = c.reg_write;
        w.mem_to_reg = c.mem_to_reg;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, illegal flag and source-register usage.
// Disabled optional opcodes fall through to the illegal path with all controls low.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit SUPPORT_JUMP  = 1'b1,
    parameter bit SUPPORT_UPPER = 1'b1
) (
    input  logic [6:0] i_op,
    output ctrl_t      o_ctrl,
    output logic       o_illegal,
    output logic       o_use_rs1,
    output logic       o_use_rs2
);

    always_comb begin
        o_ctrl    = CTRL_ZERO;
        o_illegal = 1'b0;
        o_use_rs1 = 1'b0;
        o_use_rs2 = 1'b0;
        case (i_op)
            OP_R: begin
                o_ctrl.alu_op    = ALU_RTYPE;
                o_ctrl.reg_write = 1'b1;
                o_use_rs1        = 1'b1;
                o_use_rs2        = 1'b1;
            end
            OP_IALU: begin
                o_ctrl.alu_op    = ALU_ITYPE;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_use_rs1        = 1'b1;
            end
            OP_LOAD: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = WB_MEM;
                o_use_rs1         = 1'b1;
            end
            OP_STORE: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_use_rs1        = 1'b1;
                o_use_rs2        = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl.alu_op = ALU_BRANCH;
                o_ctrl.branch = 1'b1;
                o_use_rs1     = 1'b1;
                o_use_rs2     = 1'b1;
            end
            OP_JAL: begin
                if (SUPPORT_JUMP) begin
                    o_ctrl.alu_src    = 1'b1;
                    o_ctrl.a_sel      = ASEL_PC;
                    o_ctrl.jump       = 1'b1;
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.mem_to_reg = WB_PC4;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_JALR: begin
                if (SUPPORT_JUMP) begin
                    o_ctrl.alu_src    = 1'b1;
                    o_ctrl.jump       = 1'b1;
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.mem_to_reg = WB_PC4;
                    o_use_rs1         = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_LUI: begin
                if (SUPPORT_UPPER) begin
                    o_ctrl.alu_src   = 1'b1;
                    o_ctrl.a_sel     = ASEL_ZERO;
                    o_ctrl.reg_write = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_AUIPC: begin
                if (SUPPORT_UPPER) begin
                    o_ctrl.alu_src   = 1'b1;
                    o_ctrl.a_sel     = ASEL_PC;
                    o_ctrl.reg_write = 1'b1;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control path: ID decode, load-use hazard detection, and the ID/EX,
// EX/MEM and MEM/WB control registers feeding the datapath directly.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter bit SUPPORT_JUMP  = 1'b1,
    parameter bit SUPPORT_UPPER = 1'b1,
    parameter int RA_W          = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [6:0]      Op_i,
    input  logic [RA_W-1:0] rs1_i,
    input  logic [RA_W-1:0] rs2_i,
    input  logic [RA_W-1:0] rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [1:0]      ex_ALUOp_o,
    output logic            ex_ALUSrc_o,
    output logic [1:0]      ex_ASel_o,
    output logic            ex_Branch_o,
    output logic            ex_Jump_o,
    output logic            ex_illegal_o,
    output logic            mem_MemRead_o,
    output logic            mem_MemWrite_o,
    output logic            wb_RegWrite_o,
    output logic [1:0]      wb_MemtoReg_o,
    output logic [RA_W-1:0] wb_rd_o
);

    ctrl_t           w_dec_ctrl;
    logic            w_dec_illegal;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_hz;
    logic            w_bubble;

    ctrl_t           r_ex_ctrl;
    logic [RA_W-1:0] r_ex_rd;
    logic            r_ex_illegal;
    mem_ctrl_t       r_mem_ctrl;
    logic [RA_W-1:0] r_mem_rd;
    wb_ctrl_t        r_wb_ctrl;
    logic [RA_W-1:0] r_wb_rd;

    ctrl_decode #(
        .SUPPORT_JUMP  (SUPPORT_JUMP),
        .SUPPORT_UPPER (SUPPORT_UPPER)
    ) u_decode (
        .i_op      (Op_i),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal),
        .o_use_rs1 (w_use_rs1),
        .o_use_rs2 (w_use_rs2)
    );

    // A load in EX whose destination an ID source needs: its data is not ready yet.
    assign w_hz = valid_i && r_ex_ctrl.mem_read && (r_ex_rd != '0) &&
                  ((w_use_rs1 && (rs1_i == r_ex_rd)) ||
                   (w_use_rs2 && (rs2_i == r_ex_rd)));

    assign stall_o  = w_hz && !flush_i && !rst_i;
    assign w_bubble = !valid_i || flush_i || w_hz;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex_ctrl    <= CTRL_ZERO;
            r_ex_rd      <= '0;
            r_ex_illegal <= 1'b0;
            r_mem_ctrl   <= MEM_CTRL_ZERO;
            r_mem_rd     <= '0;
            r_wb_ctrl    <= WB_CTRL_ZERO;
            r_wb_rd      <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_ctrl    <= CTRL_ZERO;
                r_ex_rd      <= '0;
                r_ex_illegal <= 1'b0;
            end else begin
                r_ex_ctrl    <= w_dec_ctrl;
                r_ex_rd      <= rd_i;
                r_ex_illegal <= w_dec_illegal;
            end
            r_mem_ctrl <= to_mem_ctrl(r_ex_ctrl);
            r_mem_rd   <= r_ex_rd;
            r_wb_ctrl  <= to_wb_ctrl(r_mem_ctrl);
            r_wb_rd    <= r_mem_rd;
        end
    end

    assign ex_ALUOp_o     = r_ex_ctrl.alu_op;
    assign ex_ALUSrc_o    = r_ex_ctrl.alu_src;
    assign ex_ASel_o      = r_ex_ctrl.a_sel;
    assign ex_Branch_o    = r_ex_ctrl.branch;
    assign ex_Jump_o      = r_ex_ctrl.jump;
    assign ex_illegal_o   = r_ex_illegal;
    assign mem_MemRead_o  = r_mem_ctrl.mem_read;
    assign mem_MemWrite_o = r_mem_ctrl.mem_write;
    assign wb_RegWrite_o  = r_wb_ctrl.reg_write;
    assign wb_MemtoReg_o  = r_wb_ctrl.mem_to_reg;
    assign wb_rd_o        = r_wb_rd;

endmodule
